// File: rtl/cbrt8_shared_as_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cbrt8_shared_as_pkg
// Purpose  : Shared definitions for the multicycle 8-bit cube-root unit:
//            FSM state encoding, shared adder/subtractor mode constants, the
//            bit-serial step constants and the trial-subtrahend helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cbrt8_shared_as_pkg;

    // FSM states, explicitly encoded
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SUB  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Shared adder/subtractor mode select
    localparam logic c_AS_ADD = 1'b1;
    localparam logic c_AS_SUB = 1'b0;

    // Shift amount sequence 6, 3, 0: one result bit per step
    localparam logic [2:0] c_S_FIRST = 3'd6;
    localparam logic [2:0] c_S_STEP  = 3'd3;

    // Trial subtrahend b = (3*y2*(y2+1) + 1) << s.
    // Operand pairs reached by the algorithm keep b below 256
    // (s=6: y2=0 -> 64; s=3: y2<=2 -> 152; s=0: y2<=6 -> 127), so 8 bits suffice.
    function automatic logic [7:0] trial_sub(input logic [2:0] y2, input logic [2:0] s);
        logic [7:0] y8;
        logic [7:0] t;
        y8 = {5'd0, y2};
        t  = 8'd3 * y8 * (y8 + 8'd1) + 8'd1;
        return t << s;
    endfunction

endpackage : cbrt8_shared_as_pkg
`default_nettype wire

// File: rtl/cbrt8_shared_as.sv
`default_nettype none
// ============================================================================
// Module   : cbrt8_shared_as
// Purpose  : Multicycle integer cube root y = floor(cbrt(x)) of an 8-bit
//            operand (result 0..6). Trial subtractions are performed by the
//            ALU's shared adder/subtractor through a req/ready port; this
//            block only compares locally.
// Ports    :
//   clk_i        in   1  clock
//   rst_i        in   1  asynchronous active-low reset
//   x_bi         in   8  radicand, sampled on the accepted start cycle
//   start_i      in   1  start pulse, honoured only while idle
//   busy_o       out  1  high while a computation is in progress
//   y_bo         out  3  result, held until the next computation completes
//   addsub_ready in   1  shared adder granted to this unit this cycle
//   addsub_res   in   8  shared adder result (combinational, same cycle)
//   addsub_req   out  1  shared adder request
//   addsub_mode  out  1  1=add, 0=subtract (a-b)
//   addsub_a     out  8  adder operand A
//   addsub_b     out  8  adder operand B
// Revision : 1.0 - initial release
// ============================================================================
module cbrt8_shared_as
    import cbrt8_shared_as_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] x_bi,
    input  logic       start_i,
    output logic       busy_o,
    output logic [2:0] y_bo,
    input  logic       addsub_ready,
    input  logic [7:0] addsub_res,
    output logic       addsub_req,
    output logic       addsub_mode,
    output logic [7:0] addsub_a,
    output logic [7:0] addsub_b
);

    state_t     r_state_q, w_state_d;
    logic [7:0] r_x_q,     w_x_d;
    logic [2:0] r_y_q,     w_y_d;
    logic [2:0] r_s_q,     w_s_d;
    logic       r_busy_q,  w_busy_d;
    logic [2:0] r_yo_q,    w_yo_d;
    logic       r_req_q,   w_req_d;
    logic       r_mode_q,  w_mode_d;
    logic [7:0] r_a_q,     w_a_d;
    logic [7:0] r_b_q,     w_b_d;

    logic [2:0] w_y2;
    logic [7:0] w_trial;
    logic       w_last;

    // y is at most 3 when doubled, so the shift never loses a bit
    assign w_y2    = r_y_q << 1;
    assign w_trial = trial_sub(w_y2, r_s_q);
    assign w_last  = (r_s_q == 3'd0);

    always_comb begin
        w_state_d = r_state_q;
        w_x_d     = r_x_q;
        w_y_d     = r_y_q;
        w_s_d     = r_s_q;
        w_busy_d  = r_busy_q;
        w_yo_d    = r_yo_q;
        w_req_d   = r_req_q;
        w_mode_d  = r_mode_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;

        case (r_state_q)
            ST_IDLE: begin
                if (start_i) begin
                    w_x_d     = x_bi;
                    w_y_d     = 3'd0;
                    w_s_d     = c_S_FIRST;
                    w_busy_d  = 1'b1;
                    w_state_d = ST_CALC;
                end
            end

            ST_CALC: begin
                // Commit the doubled y now; a successful subtraction adds 1 later
                w_y_d = w_y2;
                if (r_x_q >= w_trial) begin
                    // Bus values are registered here and frozen until the grant
                    w_req_d   = 1'b1;
                    w_mode_d  = c_AS_SUB;
                    w_a_d     = r_x_q;
                    w_b_d     = w_trial;
                    w_state_d = ST_SUB;
                end else if (w_last) begin
                    w_state_d = ST_DONE;
                end else begin
                    w_s_d = r_s_q - c_S_STEP;
                end
            end

            ST_SUB: begin
                // req is always high in this state, so ready alone is the grant
                if (addsub_ready) begin
                    w_x_d    = addsub_res;
                    w_y_d    = r_y_q + 3'd1;
                    w_req_d  = 1'b0;
                    w_mode_d = c_AS_SUB;
                    w_a_d    = 8'd0;
                    w_b_d    = 8'd0;
                    if (w_last) begin
                        w_state_d = ST_DONE;
                    end else begin
                        w_s_d     = r_s_q - c_S_STEP;
                        w_state_d = ST_CALC;
                    end
                end
            end

            ST_DONE: begin
                w_yo_d    = r_y_q;
                w_busy_d  = 1'b0;
                w_state_d = ST_IDLE;
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state_q <= ST_IDLE;
            r_x_q     <= 8'd0;
            r_y_q     <= 3'd0;
            r_s_q     <= 3'd0;
            r_busy_q  <= 1'b0;
            r_yo_q    <= 3'd0;
            r_req_q   <= 1'b0;
            r_mode_q  <= c_AS_SUB;
            r_a_q     <= 8'd0;
            r_b_q     <= 8'd0;
        end else begin
            r_state_q <= w_state_d;
            r_x_q     <= w_x_d;
            r_y_q     <= w_y_d;
            r_s_q     <= w_s_d;
            r_busy_q  <= w_busy_d;
            r_yo_q    <= w_yo_d;
            r_req_q   <= w_req_d;
            r_mode_q  <= w_mode_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
        end
    end

    assign busy_o      = r_busy_q;
    assign y_bo        = r_yo_q;
    assign addsub_req  = r_req_q;
    assign addsub_mode = r_mode_q;
    assign addsub_a    = r_a_q;
    assign addsub_b    = r_b_q;

endmodule : cbrt8_shared_as
`default_nettype wire

// File: tb/tb_cbrt8_shared_as.sv
`default_nettype none
// ============================================================================
// Module   : tb_cbrt8_shared_as
// Purpose  : Self-checking bench for cbrt8_shared_as. A driver issues
//            operations and queues the expected root; a monitor pops and
//            compares whenever busy_o falls. A bus checker watches the shared
//            adder handshake every cycle. The shared adder is modelled here.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cbrt8_shared_as;
    import cbrt8_shared_as_pkg::*;

    logic       clk_i   = 1'b0;
    logic       rst_i   = 1'b0;
    logic [7:0] x_bi    = 8'd0;
    logic       start_i = 1'b0;
    logic       busy_o;
    logic [2:0] y_bo;
    logic       addsub_ready;
    logic [7:0] addsub_res;
    logic       addsub_req;
    logic       addsub_mode;
    logic [7:0] addsub_a;
    logic [7:0] addsub_b;

    logic gnt = 1'b1;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int req_cyc = 0;

    // monitor / bus checker history
    logic       m_pb  = 1'b0;
    logic       h_req = 1'b0;
    logic       h_rdy = 1'b0;
    logic       h_mode = 1'b0;
    logic [7:0] h_a = 8'd0;
    logic [7:0] h_b = 8'd0;

    int dx[14] = '{0, 8, 27, 7, 26, 255, 216, 215, 1, 63, 64, 125, 124, 2};
    int dy[14] = '{0, 2, 3,  1, 2,  6,   6,   5,   1, 3,  4,  5,   4,   1};

    cbrt8_shared_as u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .x_bi         (x_bi),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .y_bo         (y_bo),
        .addsub_ready (addsub_ready),
        .addsub_res   (addsub_res),
        .addsub_req   (addsub_req),
        .addsub_mode  (addsub_mode),
        .addsub_a     (addsub_a),
        .addsub_b     (addsub_b)
    );

    always #5 clk_i = ~clk_i;

    // Shared adder model
    always_comb begin
        addsub_ready = gnt;
        addsub_res   = (addsub_mode == c_AS_ADD) ? (addsub_a + addsub_b) : (addsub_a - addsub_b);
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    function automatic int ref_cbrt(input int x);
        int y;
        y = 0;
        while ((y + 1) * (y + 1) * (y + 1) <= x) y++;
        return y;
    endfunction

    // Scoreboard monitor: compare the result whenever a computation completes
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                m_pb = 1'b0;
            end else begin
                if (m_pb && !busy_o) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got y_bo=%0d want no completion", y_bo);
                    end else begin
                        check("y_bo", int'(y_bo), exp_q.pop_front());
                    end
                end
                m_pb = busy_o;
            end
        end
    end

    // Shared adder handshake checker
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                h_req = 1'b0;
            end else begin
                if (!addsub_req)
                    check("idle_bus", int'({addsub_mode, addsub_a, addsub_b}), 0);
                else
                    req_cyc++;
                if (h_req && !h_rdy) begin
                    check("req_hold",  int'(addsub_req),  1);
                    check("a_hold",    int'(addsub_a),    int'(h_a));
                    check("b_hold",    int'(addsub_b),    int'(h_b));
                    check("mode_hold", int'(addsub_mode), int'(h_mode));
                end
                if (addsub_req && addsub_ready) begin
                    check("sub_mode", int'(addsub_mode), int'(c_AS_SUB));
                    check("a_ge_b",   int'(addsub_a >= addsub_b), 1);
                end
                h_req  = addsub_req;
                h_rdy  = addsub_ready;
                h_a    = addsub_a;
                h_b    = addsub_b;
                h_mode = addsub_mode;
            end
        end
    end

    // One operation: queue expectation, start, optionally withhold the grant
    // or pulse a spurious start, then check busy timing and latency.
    task automatic run_op(input logic [7:0] x, input int exp, input int hold,
                          input bit disturb, input logic [7:0] chk_a, input logic [7:0] chk_b);
        int cnt;
        int hl;
        logic [2:0] e3;
        exp_q.push_back(exp);
        x_bi    = x;
        start_i = 1'b1;
        req_cyc = 0;
        tick();
        start_i = 1'b0;
        x_bi    = ~x;
        check("busy_rise", int'(busy_o), 1);
        cnt = 0;
        hl  = hold;
        while (busy_o && cnt < 60) begin
            start_i = disturb && (cnt == 1);
            if (start_i) x_bi = 8'd200;
            if (addsub_req && hl > 0) begin
                gnt = 1'b0;
                hl--;
                check("held_a",    int'(addsub_a),    int'(chk_a));
                check("held_b",    int'(addsub_b),    int'(chk_b));
                check("held_mode", int'(addsub_mode), int'(c_AS_SUB));
            end else begin
                gnt = 1'b1;
            end
            tick();
            cnt++;
        end
        start_i = 1'b0;
        gnt     = 1'b1;
        if (busy_o) begin
            total++;
            bad++;
            $display("FAIL timeout: busy_o still 1 after %0d cycles, x=%0d", cnt, x);
        end
        e3 = exp[2:0];
        check("latency", cnt, 4 + $countones(e3) + hold);
    endtask

    initial begin
        int e;
        // reset state
        #1;
        check("rst_busy", int'(busy_o), 0);
        check("rst_y",    int'(y_bo), 0);
        check("rst_bus",  int'({addsub_req, addsub_mode, addsub_a, addsub_b}), 0);
        tick();
        tick();
        rst_i = 1'b1;
        tick();

        // x=0 issues no request
        run_op(8'd0, 0, 0, 1'b0, 8'd0, 8'd0);
        check("x0_no_req", req_cyc, 0);

        // directed vectors, back-to-back
        for (int i = 0; i < 14; i++)
            run_op(dx[i][7:0], dy[i], 0, 1'b0, 8'd0, 8'd0);

        // grant withheld 5 cycles on the first subtraction of x=64
        run_op(8'd64, 4, 5, 1'b0, 8'd64, 8'd64);

        // spurious start while busy, with a different x
        run_op(8'd8, 2, 0, 1'b1, 8'd0, 8'd0);

        // reset mid-computation (previous result 2 is nonzero)
        x_bi    = 8'd255;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        #2;
        exp_q.delete();
        rst_i = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy_o), 0);
        check("mid_rst_y",    int'(y_bo), 0);
        check("mid_rst_req",  int'(addsub_req), 0);
        check("mid_rst_a",    int'(addsub_a), 0);
        tick();
        rst_i = 1'b1;
        tick();
        run_op(8'd27, 3, 0, 1'b0, 8'd0, 8'd0);

        // exhaustive sweep
        for (int x = 0; x < 256; x++) begin
            e = ref_cbrt(x);
            run_op(x[7:0], e, 0, 1'b0, 8'd0, 8'd0);
        end

        tick();
        tick();
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cbrt8_shared_as
`default_nettype wire
